gshare_predictor: RTL and testbench
===================================

# gshare_predictor

Parametrised gshare direction predictor for the fetch stage: hashes the fetch PC with a speculative global history register (GHR) to index a table of saturating counters. It returns a taken/not-taken decision and the next-PC offset in the same cycle. It also returns a history snapshot that travels with the instruction, so the back end can train the counter and repair the GHR when a branch resolves.

## Interface
- `CNT_BIT`, 2: counter width in bits, legal range 2..4.
- `IDX_BIT`, 8: table index width; table holds 2^IDX_BIT counters.
- `HIST_LEN`, 8: GHR length in bits, legal range 1..IDX_BIT.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pd_valid`  in  1  fetch slot valid this cycle.
- `pd_pc`  in  32  PC of the fetched instruction.
- `pd_inst`  in  32  fetched instruction word.
- `pd_tk`  out  1  predicted taken.
- `pd_off`  out  32  predicted next-PC offset.
- `pd_hist`  out  HIST_LEN  GHR value used for this prediction; carried down the pipe.
- `fb_ena`  in  1  one branch resolved this cycle.
- `fb_tk`  in  1  actual outcome.
- `fb_mis`  in  1  resolved branch was mispredicted; qualified by `fb_ena`.
- `fb_pc`  in  32  PC of the resolved branch.
- `fb_hist`  in  HIST_LEN  `pd_hist` captured when that branch was predicted.

## Operation
- Opcode is `pd_inst[6:0]`.
  - Branch: 0x63. JAL: 0x6f.
- Index is `pd_pc[IDX_BIT+1:2] XOR zero_extend(ghr)`.
  - Feedback uses the same hash on `fb_pc` and `fb_hist`.
- `pd_tk`:
  - Branch: MSB of the indexed counter.
  - JAL: 1.
  - Anything else: 0.
- `pd_off`:
  - Branch: sign-extended B-immediate, `{inst[31], inst[7], inst[30:25], inst[11:8], 0}`.
  - JAL: sign-extended J-immediate, `{inst[31], inst[19:12], inst[20], inst[30:21], 0}`.
  - Anything else: 4.
- `pd_tk`, `pd_off` and `pd_hist` are combinational from the current state; they are valid irrespective of `pd_valid`.
- Speculative history: on a clock edge with `pd_valid`=1 and a branch opcode, `ghr <= {ghr[HIST_LEN-2:0], pd_tk}`.
  - JAL and non-branch instructions do not shift the GHR.
- Counter training: on a clock edge with `fb_ena`=1, the counter at the feedback index is updated.
  - `fb_tk`=1: increment, saturating at 2^CNT_BIT-1.
  - `fb_tk`=0: decrement, saturating at 0.
  - Training is independent of `pd_valid`.
- Recovery: on `fb_ena`=1 with `fb_mis`=1, `ghr <= {fb_hist[HIST_LEN-2:0], fb_tk}`.
  - Recovery wins over a simultaneous speculative shift; that shift is discarded because the younger fetch is being flushed.
- When HIST_LEN=1, a shift loads `pd_tk` and a recovery loads `fb_tk`.
- Simultaneous prediction and training of the same index: the prediction uses the pre-update counter value.
- Reset, asserted at any time (including mid-update):
  - Every counter is forced to weakly not-taken, 2^(CNT_BIT-1)-1; 01 for 2 bits.
  - The GHR is forced to 0.
  - No partial write survives.

## Timing
- Prediction latency is 0 cycles: combinational from `pd_pc`, `pd_inst`, the GHR and the table.
- A GHR shift or recovery is visible to a prediction in the cycle after the edge.
- Counter updates are visible in the cycle after the edge.
- Only one feedback is accepted per cycle; there is no backpressure and no stall output.
- Output values under reset (`rst`=0):
  - `pd_hist` = 0.
  - `pd_tk` = 0 for branches, 1 for JAL.
  - `pd_off` is the decoded offset.
- Leaving reset is synchronous to the first rising `clk` after `rst` rises. The state is already reset, so no extra cycle is needed.

## Test plan
- Reset: hold `rst`=0, release it, then present branch `pd_inst`=0x00000463 at `pd_pc`=0x100.
  - Required: `pd_tk`=0, `pd_off`=8, `pd_hist`=0.
- JAL: present `pd_inst`=0xFF9FF06F.
  - Required: `pd_tk`=1, `pd_off`=0xFFFFFFF8, and the GHR is unchanged on the next cycle.
- Saturation: send 3 feedbacks with `fb_tk`=1 at `fb_pc`=0x100, `fb_hist`=0 (counter goes 01→10→11→11).
  - Required: a prediction at PC 0x100 with GHR=0 gives `pd_tk`=1.
  - Then send 4 feedbacks with `fb_tk`=0. Required: the counter reaches 00 and stays there.
- History shift: starting from GHR=0, present 3 valid branches predicted taken/not-taken/taken.
  - Required: `pd_hist` steps 0x00→0x01→0x02→0x05.
  - Required: the index for PC 0x100 changes to 0x40^0x05=0x45.
- Recovery collision: in the same cycle, present a valid branch and `fb_ena`=1, `fb_mis`=1, `fb_tk`=0, `fb_hist`=0x3C.
  - Required: next-cycle `pd_hist`=0x78, not the speculative value.
- Asynchronous reset mid-run: drop `rst` between clock edges after training.
  - Required: the GHR is 0 and all counters are 01 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/gshare_predictor_if.sv
// Fetch/resolve port bundle for the gshare predictor: prediction request and
// response, plus the single-branch training/recovery feedback channel.
interface gshare_predictor_if #(
  parameter int HIST_LEN = 8
);
  logic                pd_valid;
  logic [31:0]         pd_pc;
  logic [31:0]         pd_inst;
  logic                pd_tk;
  logic [31:0]         pd_off;
  logic [HIST_LEN-1:0] pd_hist;

  logic                fb_ena;
  logic                fb_tk;
  logic                fb_mis;
  logic [31:0]         fb_pc;
  logic [HIST_LEN-1:0] fb_hist;

  modport master (
    output pd_valid, pd_pc, pd_inst,
    output fb_ena, fb_tk, fb_mis, fb_pc, fb_hist,
    input  pd_tk, pd_off, pd_hist
  );

  modport slave (
    input  pd_valid, pd_pc, pd_inst,
    input  fb_ena, fb_tk, fb_mis, fb_pc, fb_hist,
    output pd_tk, pd_off, pd_hist
  );
endinterface

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: PC xor speculative GHR indexes a table of
// saturating counters; prediction is combinational, training/recovery on clk.
module gshare_predictor #(
  parameter int CNT_BIT  = 2,
  parameter int IDX_BIT  = 8,
  parameter int HIST_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  gshare_predictor_if.slave    bus
);

  localparam int TBL_SIZE = 1 << IDX_BIT;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [CNT_BIT-1:0] CNT_MAX  = '1;
  localparam logic [CNT_BIT-1:0] CNT_INIT = CNT_MAX >> 1;

  function automatic logic [IDX_BIT-1:0] hash_idx(
    input logic [31:0]         pc,
    input logic [HIST_LEN-1:0] hist
  );
    logic [IDX_BIT-1:0] ext;
    ext = '0;
    ext[HIST_LEN-1:0] = hist;
    return pc[IDX_BIT+1:2] ^ ext;
  endfunction

  // Written as a shift so that HIST_LEN=1 degenerates to loading the bit.
  function automatic logic [HIST_LEN-1:0] hist_push(
    input logic [HIST_LEN-1:0] hist,
    input logic                bit_in
  );
    logic [HIST_LEN-1:0] res;
    res    = hist << 1;
    res[0] = bit_in;
    return res;
  endfunction

  function automatic logic [CNT_BIT-1:0] cnt_sat_step(
    input logic [CNT_BIT-1:0] cnt,
    input logic               up
  );
    if (up)
      return (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    else
      return (cnt == '0) ? cnt : cnt - 1'b1;
  endfunction

  logic [CNT_BIT-1:0]  r_cnt [TBL_SIZE];
  logic [HIST_LEN-1:0] r_ghr;

  logic                w_is_br;
  logic                w_is_jal;
  logic [IDX_BIT-1:0]  w_pd_idx;
  logic [IDX_BIT-1:0]  w_fb_idx;
  logic [31:0]         w_imm_b;
  logic [31:0]         w_imm_j;
  logic                w_tk;
  logic                w_recover;
  logic                w_unused;

  assign w_is_br   = (bus.pd_inst[6:0] == OP_BRANCH);
  assign w_is_jal  = (bus.pd_inst[6:0] == OP_JAL);
  assign w_pd_idx  = hash_idx(bus.pd_pc, r_ghr);
  assign w_fb_idx  = hash_idx(bus.fb_pc, bus.fb_hist);
  assign w_recover = bus.fb_ena & bus.fb_mis;

  assign w_imm_b = {{19{bus.pd_inst[31]}}, bus.pd_inst[31], bus.pd_inst[7],
                    bus.pd_inst[30:25], bus.pd_inst[11:8], 1'b0};
  assign w_imm_j = {{11{bus.pd_inst[31]}}, bus.pd_inst[31], bus.pd_inst[19:12],
                    bus.pd_inst[20], bus.pd_inst[30:21], 1'b0};

  // Counter read is the pre-update value when training hits the same entry.
  always_comb begin
    w_tk       = 1'b0;
    bus.pd_off = 32'd4;
    if (w_is_br) begin
      w_tk       = r_cnt[w_pd_idx][CNT_BIT-1];
      bus.pd_off = w_imm_b;
    end else if (w_is_jal) begin
      w_tk       = 1'b1;
      bus.pd_off = w_imm_j;
    end
  end

  assign bus.pd_tk   = w_tk;
  assign bus.pd_hist = r_ghr;

  // A mispredict flushes the younger fetch, so its speculative shift is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ghr <= '0;
    end else if (w_recover) begin
      r_ghr <= hist_push(bus.fb_hist, bus.fb_tk);
    end else if (bus.pd_valid && w_is_br) begin
      r_ghr <= hist_push(r_ghr, w_tk);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TBL_SIZE; i++) begin
        r_cnt[i] <= CNT_INIT;
      end
    end else if (bus.fb_ena) begin
      r_cnt[w_fb_idx] <= cnt_sat_step(r_cnt[w_fb_idx], bus.fb_tk);
    end
  end

  // PC bits outside the hash window do not affect the prediction.
  assign w_unused = ^{bus.pd_pc[1:0], bus.pd_pc[31:IDX_BIT+2],
                      bus.fb_pc[1:0], bus.fb_pc[31:IDX_BIT+2]};

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: decode table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_gshare_predictor;

  localparam int CNT_BIT  = 2;
  localparam int IDX_BIT  = 8;
  localparam int HIST_LEN = 8;
  localparam int TBL      = 1 << IDX_BIT;
  localparam int HMOD     = 1 << HIST_LEN;
  localparam int CMAX     = (1 << CNT_BIT) - 1;
  localparam int CHALF    = 1 << (CNT_BIT - 1);
  localparam logic [31:0] BR8 = 32'h00000463;
  localparam logic [31:0] JALM8 = 32'hFF9FF06F;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  gshare_predictor_if #(.HIST_LEN(HIST_LEN)) bus ();

  gshare_predictor #(
    .CNT_BIT (CNT_BIT),
    .IDX_BIT (IDX_BIT),
    .HIST_LEN(HIST_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "timeout");
  end

  // ---------------- behavioural model ----------------
  int unsigned m_cnt [TBL];
  int unsigned m_ghr;

  task automatic m_reset();
    for (int i = 0; i < TBL; i++) m_cnt[i] = CHALF - 1;
    m_ghr = 0;
  endtask

  function automatic int unsigned m_idx(input logic [31:0] pc, input int unsigned h);
    return ((pc / 4) % TBL) ^ h;
  endfunction

  function automatic logic m_pred_tk(input logic [31:0] pc, input logic [31:0] inst);
    int unsigned op;
    op = inst % 128;
    if (op == 'h63) return m_cnt[m_idx(pc, m_ghr)] >= CHALF;
    if (op == 'h6f) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_off(input logic [31:0] inst);
    int unsigned op;
    int imm;
    op = inst % 128;
    if (op == 'h63) begin
      imm = int'((inst >> 31) & 1) * 4096 + int'((inst >> 7) & 1) * 2048
          + int'((inst >> 25) & 63) * 32 + int'((inst >> 8) & 15) * 2;
      if (imm >= 4096) imm -= 8192;
      return 32'(imm);
    end
    if (op == 'h6f) begin
      imm = int'((inst >> 31) & 1) * (1 << 20) + int'((inst >> 12) & 255) * 4096
          + int'((inst >> 20) & 1) * 2048 + int'((inst >> 21) & 1023) * 2;
      if (imm >= (1 << 20)) imm -= (1 << 21);
      return 32'(imm);
    end
    return 32'd4;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_tk"},   32'(bus.pd_tk),   32'(m_pred_tk(bus.pd_pc, bus.pd_inst)));
    chk({tag, "_off"},  bus.pd_off,       m_off(bus.pd_inst));
    chk({tag, "_hist"}, 32'(bus.pd_hist), m_ghr);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic fe, input logic ft, input logic fm,
                       input logic [31:0] fpc, input logic [HIST_LEN-1:0] fh);
    bus.pd_valid = v;
    bus.pd_pc    = pc;
    bus.pd_inst  = inst;
    bus.fb_ena   = fe;
    bus.fb_tk    = ft;
    bus.fb_mis   = fm;
    bus.fb_pc    = fpc;
    bus.fb_hist  = fh;
  endtask

  // Advance one clock; model next state is derived from the inputs now applied.
  task automatic tick();
    logic        tk_now;
    int unsigned fi;
    tk_now = m_pred_tk(bus.pd_pc, bus.pd_inst);
    if (rst) begin
      if (bus.fb_ena) begin
        fi = m_idx(bus.fb_pc, bus.fb_hist);
        if (bus.fb_tk) m_cnt[fi] = (m_cnt[fi] == CMAX) ? CMAX : m_cnt[fi] + 1;
        else           m_cnt[fi] = (m_cnt[fi] == 0) ? 0 : m_cnt[fi] - 1;
      end
      if (bus.fb_ena && bus.fb_mis)
        m_ghr = (int'(bus.fb_hist) * 2 + int'(bus.fb_tk)) % HMOD;
      else if (bus.pd_valid && (bus.pd_inst % 128) == 'h63)
        m_ghr = (m_ghr * 2 + int'(tk_now)) % HMOD;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic train(input logic [31:0] pc, input logic [HIST_LEN-1:0] h,
                       input logic tk, input logic mis);
    drive(1'b0, 32'h100, BR8, 1'b1, tk, mis, pc, h);
    tick();
    drive(1'b0, 32'h100, BR8, 1'b0, 1'b0, 1'b0, 32'h0, '0);
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        tk;
    logic [31:0] off;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [31:0] r;
    int          sel;
    bit [2:0]    up_exp;
    bit [3:0]    dn_exp;

    n_tests = 0;
    n_fail  = 0;

    // Fresh table, GHR=0: every branch predicts not-taken.
    vecs[0]  = '{32'h100, 32'h00000463, 1'b0, 32'h00000008};
    vecs[1]  = '{32'h104, 32'hFE000EE3, 1'b0, 32'hFFFFFFFC};
    vecs[2]  = '{32'h3F8, 32'h80000063, 1'b0, 32'hFFFFF000};
    vecs[3]  = '{32'h010, 32'h7E000FE3, 1'b0, 32'h00000FFE};
    vecs[4]  = '{32'h100, 32'hFF9FF06F, 1'b1, 32'hFFFFFFF8};
    vecs[5]  = '{32'h200, 32'h0080006F, 1'b1, 32'h00000008};
    vecs[6]  = '{32'h204, 32'h800000EF, 1'b1, 32'hFFF00000};
    vecs[7]  = '{32'h208, 32'h7FFFF06F, 1'b1, 32'h000FFFFE};
    vecs[8]  = '{32'h100, 32'h00100093, 1'b0, 32'h00000004};
    vecs[9]  = '{32'h100, 32'h000080E7, 1'b0, 32'h00000004};
    vecs[10] = '{32'h100, 32'h00000023, 1'b0, 32'h00000004};
    vecs[11] = '{32'h100, 32'h0000006B, 1'b0, 32'h00000004};

    m_reset();
    rst = 1'b0;
    drive(1'b0, 32'h100, BR8, 1'b0, 1'b0, 1'b0, 32'h0, '0);
    @(negedge clk);
    @(negedge clk);

    // Outputs while held in reset
    #1;
    chk("rst_br_tk",   32'(bus.pd_tk),   32'd0);
    chk("rst_br_off",  bus.pd_off,       32'd8);
    chk("rst_hist",    32'(bus.pd_hist), 32'd0);
    drive(1'b1, 32'h100, JALM8, 1'b1, 1'b1, 1'b1, 32'h100, 8'hFF);
    #1;
    chk("rst_jal_tk",  32'(bus.pd_tk),   32'd1);
    @(negedge clk);
    chk("rst_hold_hist", 32'(bus.pd_hist), 32'd0);
    drive(1'b0, 32'h100, BR8, 1'b0, 1'b0, 1'b0, 32'h0, '0);
    rst = 1'b1;

    // Decode table
    foreach (vecs[i]) begin
      drive(1'b0, vecs[i].pc, vecs[i].inst, 1'b0, 1'b0, 1'b0, 32'h0, '0);
      #1;
      chk("vec_tk",   32'(bus.pd_tk),   32'(vecs[i].tk));
      chk("vec_off",  bus.pd_off,       vecs[i].off);
      chk("vec_hist", 32'(bus.pd_hist), 32'd0);
      tick();
    end

    // JAL: taken, offset -8, no GHR shift
    drive(1'b1, 32'h100, JALM8, 1'b0, 1'b0, 1'b0, 32'h0, '0);
    #1;
    chk("jal_tk",  32'(bus.pd_tk), 32'd1);
    chk("jal_off", bus.pd_off,     32'hFFFFFFF8);
    tick();
    drive(1'b0, 32'h100, BR8, 1'b0, 1'b0, 1'b0, 32'h0, '0);
    #1;
    chk("jal_hist", 32'(bus.pd_hist), 32'd0);

    // Saturation: 01 -> 10 -> 11 -> 11, then down to 00 and hold, then 01, 10
    up_exp = 3'b111;
    for (int k = 0; k < 3; k++) begin
      train(32'h100, '0, 1'b1, 1'b0);
      #1;
      chk("sat_up_tk", 32'(bus.pd_tk), 32'(up_exp[k]));
    end
    dn_exp = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      train(32'h100, '0, 1'b0, 1'b0);
      #1;
      chk("sat_dn_tk", 32'(bus.pd_tk), 32'(dn_exp[k]));
    end
    train(32'h100, '0, 1'b1, 1'b0);
    #1;
    chk("sat_floor_tk1", 32'(bus.pd_tk), 32'd0);
    train(32'h100, '0, 1'b1, 1'b0);
    #1;
    chk("sat_floor_tk2", 32'(bus.pd_tk), 32'd1);

    // History shift: taken / not-taken / taken -> 0x00, 0x01, 0x02, 0x05
    drive(1'b1, 32'h100, BR8, 1'b0, 1'b0, 1'b0, 32'h0, '0);
    #1;
    chk("hs0_hist", 32'(bus.pd_hist), 32'h00);
    chk("hs0_tk",   32'(bus.pd_tk),   32'd1);
    tick();
    drive(1'b1, 32'h100, BR8, 1'b0, 1'b0, 1'b0, 32'h0, '0);
    #1;
    chk("hs1_hist", 32'(bus.pd_hist), 32'h01);
    chk("hs1_tk",   32'(bus.pd_tk),   32'd0);
    tick();
    drive(1'b1, 32'h108, BR8, 1'b0, 1'b0, 1'b0, 32'h0, '0);
    #1;
    chk("hs2_hist", 32'(bus.pd_hist), 32'h02);
    chk("hs2_tk",   32'(bus.pd_tk),   32'd1);
    tick();
    drive(1'b0, 32'h100, BR8, 1'b0, 1'b0, 1'b0, 32'h0, '0);
    #1;
    chk("hs3_hist", 32'(bus.pd_hist), 32'h05);
    chk("hs3_idx45_tk", 32'(bus.pd_tk), 32'd0);
    train(32'h100, 8'h05, 1'b1, 1'b0);
    #1;
    chk("hs3_idx45_trained_tk", 32'(bus.pd_tk), 32'd1);

    // Recovery beats a simultaneous speculative shift
    drive(1'b1, 32'h100, BR8, 1'b1, 1'b0, 1'b1, 32'h100, 8'h3C);
    tick();
    drive(1'b0, 32'h100, BR8, 1'b0, 1'b0, 1'b0, 32'h0, '0);
    #1;
    chk("rec_hist", 32'(bus.pd_hist), 32'h78);
    train(32'h300, 8'h81, 1'b1, 1'b1);
    #1;
    chk("rec_msb_drop_hist", 32'(bus.pd_hist), 32'h03);

    // Same-index predict and train: prediction sees the pre-update counter
    drive(1'b0, 32'h100, BR8, 1'b1, 1'b1, 1'b0, 32'h100, 8'h03);
    #1;
    chk("same_idx_pre_tk", 32'(bus.pd_tk), 32'd0);
    tick();
    drive(1'b0, 32'h100, BR8, 1'b0, 1'b0, 1'b0, 32'h0, '0);
    #1;
    chk("same_idx_post_tk", 32'(bus.pd_tk), 32'd1);
    chk_model("dir_sync");
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      r   = $urandom;
      sel = $urandom_range(0, 3);
      if (sel < 2)       r = {r[31:7], 7'h63};
      else if (sel == 2) r = {r[31:7], 7'h6f};
      bus.pd_valid = 1'($urandom_range(0, 1));
      bus.pd_pc    = $urandom_range(0, 3) == 0 ? 32'h100 : $urandom;
      bus.pd_inst  = r;
      bus.fb_ena   = 1'($urandom_range(0, 1));
      bus.fb_tk    = 1'($urandom_range(0, 1));
      bus.fb_mis   = $urandom_range(0, 3) == 0;
      bus.fb_pc    = $urandom_range(0, 3) == 0 ? bus.pd_pc : $urandom;
      bus.fb_hist  = $urandom_range(0, 1) == 0 ? HIST_LEN'(m_ghr) : HIST_LEN'($urandom);
      #1;
      chk_model("rnd");
      tick();
    end

    // Asynchronous reset between edges after training
    drive(1'b0, 32'h100, BR8, 1'b0, 1'b0, 1'b0, 32'h0, '0);
    for (int k = 0; k < 3; k++) train(32'h200, '0, 1'b1, 1'b0);
    train(32'h300, 8'h55, 1'b1, 1'b1);
    drive(1'b0, 32'h200, BR8, 1'b0, 1'b0, 1'b0, 32'h0, '0);
    #1;
    chk("ar_pre_hist", 32'(bus.pd_hist), 32'hAB);
    #2;
    rst = 1'b0;
    m_reset();
    #1;
    chk("ar_hist", 32'(bus.pd_hist), 32'd0);
    chk("ar_tk",   32'(bus.pd_tk),   32'd0);
    @(negedge clk);
    rst = 1'b1;
    train(32'h200, '0, 1'b1, 1'b0);
    drive(1'b0, 32'h200, BR8, 1'b0, 1'b0, 1'b0, 32'h0, '0);
    #1;
    chk("ar_weak_nt_tk", 32'(bus.pd_tk), 32'd1);
    chk_model("ar_post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
